// File: rtl/conv_pkg.sv
// Shared definitions for the convolution control unit: state encoding,
// default geometry and a width helper.
package conv_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } conv_state_t;

  localparam int unsigned DEF_NUM_T = 16;
  localparam int unsigned DEF_IMG_W = 4;
  localparam int unsigned DEF_IMG_H = 4;
  localparam int unsigned DEF_K     = 3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    if (n > 1) begin
      for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Step-index to one-hot converter; enable low forces an all-zero output.
module onehot_decoder #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 4
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/conv_control_unit.sv
// Per-window timing generator with retry, continuous mode and abort.
// Optional stall counter output enabled by CONV_CTRL_STALL_CNT_EN.
module conv_control_unit
  import conv_pkg::*;
#(
  parameter int unsigned NUM_T = DEF_NUM_T,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned K     = DEF_K
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                cont,
  input  logic                                abort,
  input  logic                                E,
  input  logic                                Q,
  output logic [NUM_T-1:0]                    T,
  output logic [width_of(IMG_W-K+1)-1:0]      win_col,
  output logic [width_of(IMG_H-K+1)-1:0]      win_row,
  output logic                                busy,
  output logic                                done
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]                         stall_cnt
`endif
);

  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;
  localparam int unsigned CW    = width_of(OUT_W);
  localparam int unsigned RW    = width_of(OUT_H);
  localparam int unsigned SW    = width_of(NUM_T);

  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_T - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(OUT_W - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(OUT_H - 1);

  conv_state_t       state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [CW-1:0]     col_d;
  logic [RW-1:0]     row_d;
  logic              cont_q, cont_d;
  logic              done_d;
  logic [NUM_T-1:0]  t_d;

  // T is decoded from the next step so the output itself comes from a flop.
  onehot_decoder #(
    .N  (NUM_T),
    .IW (SW)
  ) u_dec (
    .idx    (step_d),
    .en     (state_d == ST_RUN),
    .onehot (t_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      win_col <= '0;
      win_row <= '0;
      cont_q  <= 1'b0;
      done    <= 1'b0;
      T       <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      win_col <= col_d;
      win_row <= row_d;
      cont_q  <= cont_d;
      done    <= done_d;
      T       <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    col_d   = win_col;
    row_d   = win_row;
    cont_d  = cont_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          step_d  = '0;
          col_d   = '0;
          row_d   = '0;
          cont_d  = cont;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end else if (E) begin
          if (step_q != LAST_STEP) begin
            step_d = step_q + 1'b1;
          end else begin
            step_d = '0;
            if (Q) begin
              if (win_col == LAST_COL && win_row == LAST_ROW) begin
                col_d   = '0;
                row_d   = '0;
                done_d  = 1'b1;
                state_d = cont_q ? ST_RUN : ST_IDLE;
              end else if (win_col == LAST_COL) begin
                col_d = '0;
                row_d = win_row + 1'b1;
              end else begin
                col_d = win_col + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

`ifdef CONV_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
      stall_cnt <= '0;
    end else if (state_q == ST_RUN && !E && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
